// File: rtl/hist_accumulator_pkg.sv
// Shared definitions for the histogram path (TDC, distributor, accumulator).
// Holds the default bin-address and count widths and the accumulator state
// encoding, so every block agrees on them.
package hist_accumulator_pkg;

    // Defaults shared with the TDC and the histogram distributor.
    localparam int HIST_ADDR_W = 8;
    localparam int HIST_CNT_W  = 16;

    // Width of the saturating dropped-increment counter.
    localparam int HIST_DROP_W = 8;

    // Accumulator state encoding.
    typedef logic [1:0] hist_state_t;

    localparam hist_state_t ST_CLEAR    = 2'd0;
    localparam hist_state_t ST_IDLE     = 2'd1;
    localparam hist_state_t ST_DUMP_RD  = 2'd2;
    localparam hist_state_t ST_DUMP_OUT = 2'd3;

endpackage

// File: rtl/hist_accumulator_ram.sv
// hist_ram: counter storage for the histogram accumulator.
// 2^ADDR_W words of CNT_W bits, one write port and one synchronous read port.
// A read and a write to the same address in one cycle return the old value;
// the accumulator forwards around this.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (read register only)
//   rd_en_i        issue a read of rd_addr_i this cycle
//   rd_addr_i      read address
//   rd_data_o      read data, valid the cycle after rd_en_i, held otherwise
//   wr_en_i        write wr_data_i to wr_addr_i this cycle
//   wr_addr_i      write address
//   wr_data_i      write data
module hist_ram
    import hist_accumulator_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int CNT_W  = HIST_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [CNT_W-1:0]  rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [CNT_W-1:0]  wr_data_i
);

    localparam int DEPTH = 1 << ADDR_W;

    // The array itself has no reset; the accumulator zeroes it after reset.
    logic [CNT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/hist_accumulator.sv
// hist_accumulator: per-bin event counter with a streaming dump interface.
// After reset every bin is zeroed (CLEAR). In IDLE each Memory_add strobe
// increments bin Addr (read in cycle N, write in cycle N+1, saturating).
// dump_req streams all bins out in order and clears each one as it is
// accepted.
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the word
// (out_bin/out_count/out_last) is held stable and out_valid stays high.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   Addr         bin to increment, sampled when Memory_add=1
//   Memory_add   one-cycle increment strobe
//   dump_req     one-cycle request to stream out and clear all bins
//   out_valid    output word valid
//   out_ready    consumer accepts the current word
//   out_bin      bin index of the current word
//   out_count    count of the current bin
//   out_last     current word is the highest bin
//   busy         CLEAR or dump in progress; increments are dropped
//   overflow     sticky: a bin saturated since the last dump start
//   dropped      saturating count of increments dropped while busy
//   dbg_state_o  current FSM state (debug)
module hist_accumulator
    import hist_accumulator_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int CNT_W  = HIST_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      Addr,
    input  logic                   Memory_add,
    input  logic                   dump_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_bin,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overflow,
    output logic [HIST_DROP_W-1:0] dropped,
    output hist_state_t            dbg_state_o
);

    localparam logic [ADDR_W-1:0]      IDX_MAX  = '1;
    localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
    localparam logic [HIST_DROP_W-1:0] DROP_MAX = '1;

    hist_state_t             state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic                    dump_wait_q, dump_wait_d;
    logic                    inc_v_q;
    logic [ADDR_W-1:0]       inc_addr_q;
    logic                    fwd_v_q;
    logic [ADDR_W-1:0]       fwd_addr_q;
    logic [CNT_W-1:0]        fwd_data_q;
    logic                    overflow_q, overflow_d;
    logic [HIST_DROP_W-1:0]  dropped_q, dropped_d;

    logic                    busy_w;
    logic                    accept;
    logic                    drop;
    logic                    handshake;
    logic                    dump_start;
    logic [CNT_W-1:0]        base;
    logic                    at_max;
    logic [CNT_W-1:0]        inc_val;

    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [CNT_W-1:0]        rd_data;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [CNT_W-1:0]        wr_data;

    hist_ram #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    // The wait cycle between a dump request and DUMP_RD (taken when an
    // increment arrives together with dump_req) already belongs to the dump.
    assign busy_w    = (state_q != ST_IDLE) || dump_wait_q;
    assign accept    = Memory_add && !busy_w;
    assign drop      = Memory_add && busy_w;
    assign handshake = (state_q == ST_DUMP_OUT) && out_ready;

    // The RAM returns the old value when read and written in the same cycle,
    // so a write issued in the cycle of our read is taken from the forward
    // register instead. This keeps back-to-back strobes to one bin exact.
    assign base    = (fwd_v_q && (fwd_addr_q == inc_addr_q)) ? fwd_data_q : rd_data;
    assign at_max  = (base == CNT_MAX);
    assign inc_val = at_max ? base : base + 1'b1;

    // Read port: increment lookups in IDLE, bin reads in DUMP_RD. No read is
    // issued in DUMP_OUT, so rd_data holds the current word while stalled.
    always_comb begin
        rd_en   = accept || (state_q == ST_DUMP_RD);
        rd_addr = (state_q == ST_DUMP_RD) ? idx_q : Addr;
    end

    // Write port: increment write-back, CLEAR sweep, clear-on-accept.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (inc_v_q) begin
            wr_en   = 1'b1;
            wr_addr = inc_addr_q;
            wr_data = inc_val;
        end else if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
        end else if (handshake) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_wait_d = 1'b0;
        dump_start  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (idx_q == IDX_MAX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (dump_wait_q) begin
                    dump_start = 1'b1;
                end else if (dump_req) begin
                    // A strobe in the request cycle writes next cycle; wait
                    // one cycle so the dump reads the updated bin.
                    if (accept) begin
                        dump_wait_d = 1'b1;
                    end else begin
                        dump_start = 1'b1;
                    end
                end
                if (dump_start) begin
                    state_d = ST_DUMP_RD;
                    idx_d   = '0;
                end
            end
            ST_DUMP_RD: begin
                state_d = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (out_ready) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_DUMP_RD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (dump_start) begin
            overflow_d = 1'b0;
            dropped_d  = drop ? {{(HIST_DROP_W-1){1'b0}}, 1'b1} : '0;
        end else begin
            if (inc_v_q && at_max) begin
                overflow_d = 1'b1;
            end
            if (drop && (dropped_q != DROP_MAX)) begin
                dropped_d = dropped_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            idx_q       <= '0;
            dump_wait_q <= 1'b0;
            inc_v_q     <= 1'b0;
            inc_addr_q  <= '0;
            fwd_v_q     <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            overflow_q  <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_wait_q <= dump_wait_d;
            inc_v_q     <= accept;
            if (accept) begin
                inc_addr_q <= Addr;
            end
            fwd_v_q     <= wr_en;
            fwd_addr_q  <= wr_addr;
            fwd_data_q  <= wr_data;
            overflow_q  <= overflow_d;
            dropped_q   <= dropped_d;
        end
    end

    assign out_valid   = (state_q == ST_DUMP_OUT);
    assign out_bin     = out_valid ? idx_q : '0;
    assign out_count   = out_valid ? rd_data : '0;
    assign out_last    = out_valid && (idx_q == IDX_MAX);
    assign busy        = busy_w;
    assign overflow    = overflow_q;
    assign dropped     = dropped_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/hist_accumulator.md
HIST_ACCUMULATOR -- requirements
Module: hist_accumulator

Interface
REQ-001 Parameter: ADDR_W, default 8, meaning bin-address width (2^ADDR_W bins).
REQ-002 Parameter: CNT_W, default 16, meaning per-bin count width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Addr  input  ADDR_W  bin to increment; sampled only when Memory_add=1.
REQ-006 Memory_add  input  1  one-cycle increment strobe from the histogram distributor.
REQ-007 dump_req  input  1  one-cycle request to stream out and clear all bins.
REQ-008 out_valid  output  1  out_bin/out_count/out_last valid.
REQ-009 out_ready  input  1  consumer accepts the current word.
REQ-010 out_bin  output  ADDR_W  bin index of the current word.
REQ-011 out_count  output  CNT_W  count of the current bin.
REQ-012 out_last  output  1  current word is the highest bin.
REQ-013 busy  output  1  block is in CLEAR or dump; increments are not accepted.
REQ-014 overflow  output  1  sticky: some bin saturated since the last dump start.
REQ-015 dropped  output  8  saturating count of increments discarded while busy.

Function
REQ-016 The block SHALL hold 2^ADDR_W counters of CNT_W bits in a single-port-write, synchronous-read array.
REQ-017 States SHALL be CLEAR, IDLE, DUMP_RD, DUMP_OUT.
REQ-018 CLEAR: write zero to bins 0..2^ADDR_W-1, one per cycle, then go to IDLE; busy=1 throughout.
REQ-019 IDLE: Memory_add=1 at cycle N reads Addr; cycle N+1 writes count+1; updated value is readable from cycle N+2.
REQ-020 Back-to-back strobes to the same bin (including every cycle) SHALL forward the pending write so that no increment is lost.
REQ-021 Increment SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set overflow.
REQ-022 Memory_add while busy=1 SHALL be dropped and SHALL increment dropped (saturating at 255).
REQ-023 dump_req in IDLE SHALL complete any in-flight increment, then enter DUMP_RD with index 0 and clear overflow and dropped.
REQ-024 dump_req outside IDLE SHALL be ignored.
REQ-025 DUMP_RD: issue read of the current index; next cycle go to DUMP_OUT.
REQ-026 DUMP_OUT: out_valid=1; out_bin, out_count, out_last held stable until out_valid&&out_ready.
REQ-027 On handshake: write zero to the current bin; if out_last, go to IDLE; else index+1 and go to DUMP_RD.
REQ-028 Throughput: one word per two cycles with out_ready held high; latency from dump_req to first out_valid is 2 cycles (3 if an increment is in flight).
REQ-029 out_valid SHALL never drop without a handshake; out_last=1 only for bin 2^ADDR_W-1.
REQ-030 Simultaneous Memory_add and dump_req in IDLE: the increment SHALL be applied and included in the dump.

Reset
REQ-031 While rst_n=0: state=CLEAR, index=0, out_valid=0, out_bin=0, out_count=0, out_last=0, busy=1, overflow=0, dropped=0.
REQ-032 Reset asserted mid-dump SHALL abort the stream immediately (out_valid=0); after release, CLEAR re-zeroes the whole array.

Structure
REQ-033 The shared package SHALL hold the state enumeration and the ADDR_W/CNT_W defaults shared with the TDC and distributor.
REQ-034 The counter array with its synchronous read port SHALL be one sub-module, hist_ram; the FSM, forwarding and saturation logic live in hist_accumulator.

Verification
REQ-035 Reset release -> busy=1 for exactly 256 cycles, then 0; a subsequent dump returns 256 words, all count 0.
REQ-036 Memory_add on Addr=5 for 10 consecutive cycles, then dump with out_ready=1 -> bin 5 count=10, all other bins 0, out_last only on bin 255.
REQ-037 Alternating strobes Addr=3,3,7,3 back-to-back -> bin 3=3, bin 7=1.
REQ-038 70000 strobes on Addr=0 -> count 65535, overflow=1; after dump, overflow=0 and bin 0 reads 0 on the next dump.
REQ-039 out_ready toggled randomly during dump -> words in order 0..255, each held stable while stalled; 5 strobes during dump -> dropped=5, counts unchanged.
REQ-040 rst_n pulsed low at bin 100 of a dump -> out_valid=0 immediately, CLEAR runs 256 cycles, next dump returns all zeros.
